accum_requant_unit: RTL
=======================

// Module: accum_requant_unit
// PURPOSE
// - Stage directly upstream of the activation controller. Accumulates NUM_ELEMENTS signed partial-sum lanes over a programmable
//   number of input beats, requantises each lane (arithmetic right shift + signed saturation) to DATA_WIDTH, then drives the
//   packed vector into the activation controller with a one-cycle start pulse and holds it stable until done returns.
// PARAMETERS
// - NUM_ELEMENTS  16  lanes per vector; must equal the activation controller's NUM_ELEMENTS
// - DATA_WIDTH    16  signed lane width on in_data/out_data
// - ACC_WIDTH     32  signed accumulator width; must be >= DATA_WIDTH + PASS_WIDTH (accumulators wrap otherwise, not checked)
// - PASS_WIDTH    8   width of cfg_pass_count
// - SHIFT_WIDTH   5   width of cfg_shift (shift range 0..2^SHIFT_WIDTH-1, must be < ACC_WIDTH)
// PORTS
// - clk             in   1                          rising-edge clock
// - reset_n         in   1                          asynchronous, active-low reset
// - cfg_start       in   1                          pulse: begin a job (accepted only in IDLE)
// - cfg_pass_count  in   PASS_WIDTH                 beats to accumulate; 0 treated as 1
// - cfg_shift       in   SHIFT_WIDTH                requantisation right-shift amount
// - in_valid        in   1                          partial-sum beat valid
// - in_ready        out  1                          beat accepted when in_valid & in_ready
// - in_data         in   NUM_ELEMENTS*DATA_WIDTH    signed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
// - act_start       out  1                          one-cycle start to activation controller
// - act_done        in   1                          done level from activation controller
// - out_data        out  NUM_ELEMENTS*DATA_WIDTH    requantised vector, same lane packing as in_data
// - busy            out  1                          high in every state except IDLE
// - sat_flag        out  1                          sticky: any lane saturated in the current/last job
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE; accumulators, beat counter, out_data=0; in_ready=0, act_start=0, busy=0, sat_flag=0.
// - FSM: IDLE -> ACCUM -> REQUANT -> KICK -> WAIT_DONE -> IDLE. All outputs registered or decoded from state only.
// - IDLE: cfg_start=1 latches pass_count (0->1) and shift, clears accumulators, beat counter and sat_flag; next ACCUM.
// - ACCUM: in_ready=1. Per accepted beat acc[i] <= acc[i] + sext(lane i); counter++. On acceptance of final beat -> REQUANT.
//   in_valid=0 stalls indefinitely; no timeout.
// - REQUANT (1 cycle): out_data lane i <= sat(acc[i] >>> shift); shift is arithmetic (rounds toward -inf); sat clamps to
//   [-2^(DW-1), 2^(DW-1)-1]; sat_flag <= 1 if any lane clamped. Next KICK.
// - KICK (1 cycle): act_start=1. act_done ignored here (downstream done may still be high from the prior job). Next WAIT_DONE.
// - WAIT_DONE: act_done=1 -> IDLE. out_data held unchanged from REQUANT until next REQUANT (downstream reads it serially).
// - Latency: last beat accepted at edge N -> act_start high during cycle N+2; first new job may start one cycle after act_done.
// - cfg_start outside IDLE ignored; in_valid outside ACCUM ignored (in_ready=0, no data consumed).
// - cfg_start and in_valid together in IDLE: only cfg_start acts; first beat can be accepted next cycle.
// - Beat counter compares against latched count; no wrap since count <= 2^PASS_WIDTH-1.
// - Reset mid-job: immediate return to IDLE, partial accumulation discarded, act_start deasserts asynchronously.
// STRUCTURE
// - Package accel_pkg: state enum (IDLE, ACCUM, REQUANT, KICK, WAIT_DONE), lane-slice helper, saturation constants.
// - Sub-module accum_lane (one per lane, generate loop): holds acc, clear/add controls, combinational shift+saturate output + sat bit.
// - Top: FSM, beat counter, config latches, out_data register, OR-reduction of lane sat bits.
// TESTING
// - pass_count=1, shift=0, all lanes=5 -> act_start 2 cycles after accept, out_data all lanes 5, sat_flag=0.
// - pass_count=4, shift=2, lane0 beats 100,200,-50,30 -> acc 280, out lane0=70; lane1 beats all -3 -> -12>>>2 = -3.
// - pass_count=2, shift=0, lane3 beats 30000,30000 -> lane3=32767, sat_flag=1; lane4 -30000 x2 -> -32768.
// - act_done held 1 during KICK -> FSM stays in WAIT_DONE; act_done 1 five cycles later -> IDLE, busy=0 next cycle.
// - in_valid toggling 1,0,0,1,1 with pass_count=3 -> exactly 3 beats consumed; cfg_start mid-ACCUM ignored.
// - reset_n low during ACCUM after 2 of 4 beats -> all outputs 0 at once; new job from cfg_start sums fresh beats only.

Source files
------------

// File: rtl/accel_pkg.sv
// ============================================================================
// Module : accel_pkg
// Brief  : Shared FSM state encoding and lane helpers for the accumulator stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package accel_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        REQUANT   = 3'd2,
        KICK      = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    // Saturation bounds for the default 16-bit lane width.
    localparam int SAT_MAX_DW16 = 32767;
    localparam int SAT_MIN_DW16 = -32768;

    // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/accum_lane.sv
// ============================================================================
// Module : accum_lane
// Brief  : One signed accumulator lane with arithmetic shift and saturation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module accum_lane #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   add,
    input  logic [DATA_WIDTH-1:0]  lane_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0]  lane_out,
    output logic                   lane_sat
);

    localparam logic signed [ACC_WIDTH-1:0] C_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_MIN = ~C_MAX;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (add) begin
            r_acc <= r_acc + {{(ACC_WIDTH-DATA_WIDTH){lane_in[DATA_WIDTH-1]}}, lane_in};
        end
    end

    // Arithmetic shift rounds toward -inf; clamp to the signed lane range.
    always_comb begin
        w_shifted = r_acc >>> shift;
        lane_sat  = 1'b0;
        lane_out  = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > C_MAX) begin
            lane_out = C_MAX[DATA_WIDTH-1:0];
            lane_sat = 1'b1;
        end else if (w_shifted < C_MIN) begin
            lane_out = C_MIN[DATA_WIDTH-1:0];
            lane_sat = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/accum_requant_unit.sv
// ============================================================================
// Module : accum_requant_unit
// Brief  : Multi-beat lane accumulation, requantisation and activation kick-off.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module accum_requant_unit
    import accel_pkg::*;
#(
    parameter int NUM_ELEMENTS = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int PASS_WIDTH   = 8,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cfg_start,
    input  logic [PASS_WIDTH-1:0]              cfg_pass_count,
    input  logic [SHIFT_WIDTH-1:0]             cfg_shift,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
    output logic                               act_start,
    input  logic                               act_done,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
    output logic                               busy,
    output logic                               sat_flag
);

    localparam logic [PASS_WIDTH-1:0] C_ONE = PASS_WIDTH'(1);

    state_t                             r_state;
    state_t                             w_next_state;
    logic [PASS_WIDTH-1:0]              r_count;
    logic [PASS_WIDTH-1:0]              r_pass;
    logic [SHIFT_WIDTH-1:0]             r_shift;
    logic [NUM_ELEMENTS*DATA_WIDTH-1:0] r_out_data;
    logic                               r_sat_flag;
    logic [NUM_ELEMENTS*DATA_WIDTH-1:0] w_lane_bus;
    logic [NUM_ELEMENTS-1:0]            w_lane_sat;
    logic                               w_clear;
    logic                               w_add;
    logic                               w_last;

    assign w_clear = (r_state == IDLE) && cfg_start;
    assign w_add   = (r_state == ACCUM) && in_valid;
    assign w_last  = (r_count == (r_pass - C_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (cfg_start) w_next_state = ACCUM;
            ACCUM:     if (in_valid && w_last) w_next_state = REQUANT;
            REQUANT:   w_next_state = KICK;
            KICK:      w_next_state = WAIT_DONE;
            WAIT_DONE: if (act_done) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_pass     <= C_ONE;
            r_shift    <= '0;
            r_out_data <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_clear) begin
                r_pass     <= (cfg_pass_count == '0) ? C_ONE : cfg_pass_count;
                r_shift    <= cfg_shift;
                r_count    <= '0;
                r_sat_flag <= 1'b0;
            end
            if (w_add) begin
                r_count <= r_count + C_ONE;
            end
            // out_data stays frozen outside REQUANT; downstream reads it serially.
            if (r_state == REQUANT) begin
                r_out_data <= w_lane_bus;
                r_sat_flag <= r_sat_flag | (|w_lane_sat);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane
        accum_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (w_clear),
            .add      (w_add),
            .lane_in  (in_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .shift    (r_shift),
            .lane_out (w_lane_bus[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .lane_sat (w_lane_sat[gi])
        );
    end

    assign in_ready  = (r_state == ACCUM);
    assign act_start = (r_state == KICK);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;

endmodule

`default_nettype wire
